// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants and the hazard FSM state encoding.
// Also used by the forwarding and flush logic elsewhere in the core.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_X0        = 5'd0;
  // addi x0, x0, 0: what a flushed pipeline register decodes as
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Load-use detector: the ID instruction needs a register that the load in EX
// has not produced yet. It uses the same compare style as the forwarding unit.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs1_i,
  input  logic [4:0] ID_rs2_i,
  input  logic       ID_use_rs1_i,
  input  logic       ID_use_rs2_i,
  input  logic       EX_MemRead_i,
  input  logic [4:0] EX_rd_i,
  output logic       load_use_o
);

  logic hit_rs1, hit_rs2;

  assign hit_rs1    = ID_use_rs1_i && (ID_rs1_i == EX_rd_i);
  assign hit_rs2    = ID_use_rs2_i && (ID_rs2_i == EX_rd_i);
  assign load_use_o = EX_MemRead_i && (EX_rd_i != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller. It handles load-use bubbles, EX-resolved
// redirects and multi-cycle MDU ops, and keeps a perf count of PC stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_STALL = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rd,
  input  logic        EX_mdu_op,
  input  logic        EX_redirect,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_stall,
  output logic        ID_EX_flush,
  output logic        EX_MEM_bubble,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  // The RUN cycle that accepts the op is the first stall, so BUSY counts down the rest.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((MDU_STALL >= 2) ? (MDU_STALL - 2) : 0);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              load_use;

  load_use_detect u_lud (
    .ID_rs1_i     (ID_rs1),
    .ID_rs2_i     (ID_rs2),
    .ID_use_rs1_i (ID_use_rs1),
    .ID_use_rs2_i (ID_use_rs2),
    .EX_MemRead_i (EX_MemRead),
    .EX_rd_i      (EX_rd),
    .load_use_o   (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PC_stall      = 1'b0;
    IF_ID_stall   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_stall   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        if (EX_redirect) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (EX_mdu_op) begin
          PC_stall      = 1'b1;
          IF_ID_stall   = 1'b1;
          ID_EX_stall   = 1'b1;
          EX_MEM_bubble = 1'b1;
          if (MDU_STALL == 1) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_RELOAD;
            state_d = BUSY;
          end
        end else if (load_use) begin
          PC_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_EX_flush = 1'b1;
        end
      end
      BUSY: begin
        PC_stall      = 1'b1;
        IF_ID_stall   = 1'b1;
        ID_EX_stall   = 1'b1;
        EX_MEM_bubble = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
    if (rst) begin
      PC_stall      = 1'b0;
      IF_ID_stall   = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_stall   = 1'b0;
      ID_EX_flush   = 1'b0;
      EX_MEM_bubble = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PC_stall && (stall_cnt_q != STALL_CNT_MAX)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdu_busy  = (state_q == BUSY) && !rst;
  assign stall_cnt = stall_cnt_q;

endmodule
